// File: rtl/conv_mac_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac_engine_pkg
//  Purpose  : Shared state encoding, memory-geometry helpers and the
//             saturation classifier for the convolution MAC engine.
//  Revision : 1.0  initial release
// ============================================================================
package conv_mac_engine_pkg;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MAC  = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;
    localparam logic [1:0] c_ST_OUT  = 2'd3;

    // Taps per output channel: every input channel times the KxK window
    function automatic int calc_taps(input int in_ch, input int k);
        return in_ch * k * k;
    endfunction

    // Weights for every output channel followed by one bias per channel
    function automatic int calc_depth(input int in_ch, input int out_ch, input int k);
        return out_ch * (calc_taps(in_ch, k) + 1);
    endfunction

    function automatic int calc_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Classify a value against the signed range of a dw-bit word:
    // 2'b01 above the maximum, 2'b10 below the minimum, 2'b00 in range
    function automatic logic [1:0] sat_class(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return 2'b01;
        end
        if (v < lo) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac_engine_if
//  Purpose  : Weight-load port, window input and pixel output handshakes of
//             the convolution MAC engine. The engine uses the slave view.
//  Revision : 1.0  initial release
// ============================================================================
interface conv_mac_engine_if #(
    parameter int IN_CHANNELS       = 12,
    parameter int OUT_CHANNELS      = 12,
    parameter int KERNEL_SIZE       = 3,
    parameter int DATA_WIDTH        = 16,
    parameter int WEIGHT_ADDR_WIDTH = 20
);
    logic                                                   weight_we;
    logic [WEIGHT_ADDR_WIDTH-1:0]                           weight_addr;
    logic [DATA_WIDTH-1:0]                                  weight_in;
    logic                                                   wr_dropped;
    logic                                                   in_valid;
    logic                                                   in_ready;
    logic [IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_in;
    logic                                                   relu_en;
    logic                                                   out_valid;
    logic                                                   out_ready;
    logic [OUT_CHANNELS*DATA_WIDTH-1:0]                     pixel_out;
    logic                                                   busy;

    modport slave (
        input  weight_we, weight_addr, weight_in, in_valid, window_in, relu_en, out_ready,
        output wr_dropped, in_ready, out_valid, pixel_out, busy
    );

    modport master (
        output weight_we, weight_addr, weight_in, in_valid, window_in, relu_en, out_ready,
        input  wr_dropped, in_ready, out_valid, pixel_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/conv_mac_engine_weight_ram.sv
`default_nettype none
// ============================================================================
//  Module   : conv_weight_ram
//  Purpose  : Single-port weight/bias store, synchronous write, registered
//             one-cycle read. Contents are not cleared by reset.
//  Revision : 1.0  initial release
// ============================================================================
module conv_weight_ram #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write-first is irrelevant here: reads and writes never target the same job
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/conv_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac_engine
//  Purpose  : Computes all output channels of one KxK multi-channel window
//             with a single time-shared signed multiplier, Q-format bias,
//             optional ReLU and signed saturation; result held until taken.
//  Revision : 1.0  initial release
// ============================================================================
module conv_mac_engine
    import conv_mac_engine_pkg::*;
#(
    parameter int IN_CHANNELS       = 12,
    parameter int OUT_CHANNELS      = 12,
    parameter int KERNEL_SIZE       = 3,
    parameter int DATA_WIDTH        = 16,
    parameter int FRAC_BITS         = 8,
    parameter int ACC_WIDTH         = 2*DATA_WIDTH+8,
    parameter int WEIGHT_ADDR_WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_mac_engine_if.slave bus
);
    localparam int c_N         = calc_taps(IN_CHANNELS, KERNEL_SIZE);
    localparam int c_DEPTH     = calc_depth(IN_CHANNELS, OUT_CHANNELS, KERNEL_SIZE);
    localparam int c_AW        = calc_addr_width(c_DEPTH);
    localparam int c_BIAS_BASE = OUT_CHANNELS * c_N;
    localparam int c_TW        = $clog2(c_N + 2);
    localparam int c_OW        = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int c_PW        = 2 * DATA_WIDTH;

    logic [1:0]                    r_state;
    logic [c_N*DATA_WIDTH-1:0]     r_window;
    logic                          r_relu;
    logic [c_OW-1:0]               r_oc;
    logic [c_TW-1:0]               r_tap;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [OUT_CHANNELS*DATA_WIDTH-1:0] r_pix;
    logic                          r_out_valid;
    logic                          r_wr_dropped;
    logic                          r_v1;
    logic                          r_v2;
    logic [DATA_WIDTH-1:0]         r_samp;
    logic signed [c_PW-1:0]        r_prod;

    logic                          w_idle;
    logic                          w_tap_lt_n;
    logic                          w_last_tap;
    logic                          w_last_oc;
    logic                          w_addr_ok;
    logic                          w_ram_we;
    logic [c_AW-1:0]               w_rd_addr;
    logic [c_AW-1:0]               w_ram_addr;
    logic [DATA_WIDTH-1:0]         w_rdata;
    int                            w_lane_sel;
    logic [DATA_WIDTH-1:0]         w_samp;
    logic signed [c_PW-1:0]        w_rdata_ext;
    logic signed [c_PW-1:0]        w_samp_ext;
    logic signed [ACC_WIDTH-1:0]   w_bias_ext;
    logic signed [ACC_WIDTH-1:0]   w_shr;
    logic signed [63:0]            w_wide;
    logic [DATA_WIDTH-1:0]         w_lane;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_tap_lt_n = (int'(r_tap) < c_N);
    assign w_last_tap = (int'(r_tap) == c_N + 1);
    assign w_last_oc  = (int'(r_oc) == OUT_CHANNELS - 1);

    // Writes only land while idle and inside the weight/bias table
    assign w_addr_ok  = (int'(bus.weight_addr) < c_DEPTH);
    assign w_ram_we   = bus.weight_we && w_idle && w_addr_ok;

    // Weight address while streaming taps, bias address in the drain cycles
    always_comb begin
        w_rd_addr = c_AW'(c_BIAS_BASE + int'(r_oc));
        if (w_tap_lt_n) begin
            w_rd_addr = c_AW'(int'(r_oc) * c_N + int'(r_tap));
        end
    end

    assign w_ram_addr = w_idle ? bus.weight_addr[c_AW-1:0] : w_rd_addr;

    conv_weight_ram #(
        .DEPTH      (c_DEPTH),
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (bus.weight_in),
        .rdata (w_rdata)
    );

    // Sample for the tap being read; the window index equals the tap count
    assign w_lane_sel  = w_tap_lt_n ? int'(r_tap) : 0;
    assign w_samp      = r_window[w_lane_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_rdata_ext = {{DATA_WIDTH{w_rdata[DATA_WIDTH-1]}}, w_rdata};
    assign w_samp_ext  = {{DATA_WIDTH{r_samp[DATA_WIDTH-1]}}, r_samp};

    // Finalise: add Q-aligned bias, floor-shift back, then ReLU and clamp
    assign w_bias_ext  = {{(ACC_WIDTH-DATA_WIDTH){w_rdata[DATA_WIDTH-1]}}, w_rdata};
    assign w_shr       = (r_acc + (w_bias_ext <<< FRAC_BITS)) >>> FRAC_BITS;
    assign w_wide      = {{(64-ACC_WIDTH){w_shr[ACC_WIDTH-1]}}, w_shr};

    // Select saturated or passed-through lane value
    always_comb begin
        w_lane = w_shr[DATA_WIDTH-1:0];
        case (sat_class(w_wide, DATA_WIDTH))
            2'b01:   w_lane = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            2'b10:   w_lane = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            default: w_lane = w_shr[DATA_WIDTH-1:0];
        endcase
        if (r_relu && w_shr[ACC_WIDTH-1]) begin
            w_lane = '0;
        end
    end

    // Read/multiply pipeline: RAM register stage, then product register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_samp <= '0;
            r_prod <= '0;
        end else begin
            r_v1   <= (r_state == c_ST_MAC) && w_tap_lt_n;
            r_v2   <= r_v1;
            r_samp <= w_samp;
            r_prod <= w_rdata_ext * w_samp_ext;
        end
    end

    // Job controller: accept, per-channel MAC sweep, finalise, hold result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_window    <= '0;
            r_relu      <= 1'b0;
            r_oc        <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_pix       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_window <= bus.window_in;
                        r_relu   <= bus.relu_en;
                        r_oc     <= '0;
                        r_tap    <= '0;
                        r_acc    <= '0;
                        r_state  <= c_ST_MAC;
                    end
                end
                c_ST_MAC: begin
                    if (r_v2) begin
                        r_acc <= r_acc + {{(ACC_WIDTH-c_PW){r_prod[c_PW-1]}}, r_prod};
                    end
                    if (w_last_tap) begin
                        r_tap   <= '0;
                        r_state <= c_ST_FIN;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                c_ST_FIN: begin
                    r_pix[int'(r_oc)*DATA_WIDTH +: DATA_WIDTH] <= w_lane;
                    r_acc <= '0;
                    if (w_last_oc) begin
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_OUT;
                    end else begin
                        r_oc    <= r_oc + 1'b1;
                        r_state <= c_ST_MAC;
                    end
                end
                c_ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Flag any write strobe that did not reach the memory
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_dropped <= 1'b0;
        end else begin
            r_wr_dropped <= bus.weight_we && !w_ram_we;
        end
    end

    assign bus.in_ready   = w_idle;
    assign bus.busy       = !w_idle;
    assign bus.out_valid  = r_out_valid;
    assign bus.pixel_out  = r_pix;
    assign bus.wr_dropped = r_wr_dropped;
endmodule
`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_mac_engine
//  Purpose  : Self-checking bench: a 1x1x1 engine for directed vectors and
//             corner sequences, a default-size engine against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_mac_engine;
    localparam int N_B    = 108;
    localparam int OC_B   = 12;
    localparam int BIAS_B = OC_B * N_B;
    localparam int DEPTH_B = OC_B * (N_B + 1);

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    always #5 clk = ~clk;

    conv_mac_engine_if #(.IN_CHANNELS(1), .OUT_CHANNELS(1), .KERNEL_SIZE(1),
                         .DATA_WIDTH(16), .WEIGHT_ADDR_WIDTH(20)) ia ();
    conv_mac_engine_if ib ();

    conv_mac_engine #(.IN_CHANNELS(1), .OUT_CHANNELS(1), .KERNEL_SIZE(1)) u_small (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ia.slave)
    );

    conv_mac_engine u_full (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ib.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] x;
        bit          relu;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [10];
    int   wm [DEPTH_B];
    int   xs [N_B];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input int addr, input logic [15:0] d);
        ia.weight_we   = 1'b1;
        ia.weight_addr = 20'(addr);
        ia.weight_in   = d;
        tick();
        ia.weight_we   = 1'b0;
    endtask

    task automatic a_start(input logic [15:0] x, input bit relu);
        int n;
        n = 0;
        ia.window_in = x;
        ia.relu_en   = relu;
        ia.in_valid  = 1'b1;
        while (!ia.in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        ia.in_valid = 1'b0;
    endtask

    task automatic a_wait_out(output int lat);
        lat = 0;
        while (!ia.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic a_handshake();
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
    endtask

    task automatic b_write(input int addr, input logic [15:0] d);
        ib.weight_we   = 1'b1;
        ib.weight_addr = 20'(addr);
        ib.weight_in   = d;
        tick();
        ib.weight_we   = 1'b0;
    endtask

    task automatic b_job(input bit relu, output int lat);
        int n;
        n = 0;
        for (int t = 0; t < N_B; t++) begin
            ib.window_in[t*16 +: 16] = 16'(xs[t]);
        end
        ib.relu_en  = relu;
        ib.in_valid = 1'b1;
        while (!ib.in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        ib.in_valid = 1'b0;
        lat = 0;
        while (!ib.out_valid && lat < 3000) begin
            tick();
            lat++;
        end
    endtask

    // Reference: dot product in plain integers, Q-aligned bias, wrap, floor, clamp
    function automatic logic [15:0] ref_lane(input int oc, input bit relu);
        longint acc;
        longint r;
        acc = 0;
        for (int t = 0; t < N_B; t++) begin
            acc += longint'(wm[oc*N_B + t]) * longint'(xs[t]);
        end
        acc += longint'(wm[BIAS_B + oc]) * 256;
        acc = (acc <<< 24) >>> 24;
        r = acc >>> 8;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic signed [15:0] rnd;

        vt[0] = '{16'h0100, 16'h0080, 16'h0200, 1'b0, 16'h0280};
        vt[1] = '{16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 16'h7FFF};
        vt[2] = '{16'h8000, 16'h0000, 16'h7FFF, 1'b0, 16'h8000};
        vt[3] = '{16'h8000, 16'h0000, 16'h7FFF, 1'b1, 16'h0000};
        vt[4] = '{16'hFFFF, 16'h0000, 16'h0001, 1'b0, 16'hFFFF};
        vt[5] = '{16'h0100, 16'h0010, 16'hFF00, 1'b0, 16'hFF10};
        vt[6] = '{16'h0100, 16'h0010, 16'hFF00, 1'b1, 16'h0000};
        vt[7] = '{16'h0000, 16'h8000, 16'h1234, 1'b0, 16'h8000};
        vt[8] = '{16'h0080, 16'h0000, 16'h0003, 1'b0, 16'h0001};
        vt[9] = '{16'h0080, 16'hFFFF, 16'h0003, 1'b0, 16'h0000};

        ia.weight_we = 1'b0; ia.weight_addr = '0; ia.weight_in = '0;
        ia.in_valid = 1'b0; ia.window_in = '0; ia.relu_en = 1'b0; ia.out_ready = 1'b0;
        ib.weight_we = 1'b0; ib.weight_addr = '0; ib.weight_in = '0;
        ib.in_valid = 1'b0; ib.window_in = '0; ib.relu_en = 1'b0; ib.out_ready = 1'b0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        tick();
        tick();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Reset state
        check("rst out_valid", 64'(ia.out_valid), 64'd0);
        check("rst pixel_out", 64'(ia.pixel_out), 64'd0);
        check("rst busy", 64'(ia.busy), 64'd0);
        check("rst in_ready", 64'(ia.in_ready), 64'd1);
        check("rst wr_dropped", 64'(ia.wr_dropped), 64'd0);
        check("rst full out_valid", 64'(ib.out_valid), 64'd0);
        check("rst full in_ready", 64'(ib.in_ready), 64'd1);

        // Directed 1x1x1 vectors
        for (int i = 0; i < 10; i++) begin
            a_write(0, vt[i].w);
            check("idle write no drop", 64'(ia.wr_dropped), 64'd0);
            a_write(1, vt[i].b);
            a_start(vt[i].x, vt[i].relu);
            check("in_ready low in MAC", 64'(ia.in_ready), 64'd0);
            a_wait_out(lat);
            check("vec latency", 64'(lat), 64'd4);
            check("vec pixel", 64'(ia.pixel_out), 64'(vt[i].exp));
            a_handshake();
        end

        // Backpressure with a second window waiting
        a_write(0, 16'h0100);
        a_write(1, 16'h0000);
        a_start(16'h0200, 1'b0);
        a_wait_out(lat);
        ia.window_in = 16'h0300;
        ia.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp out_valid", 64'(ia.out_valid), 64'd1);
            check("bp pixel", 64'(ia.pixel_out), 64'h0200);
            check("bp in_ready", 64'(ia.in_ready), 64'd0);
        end
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        check("post hs in_ready", 64'(ia.in_ready), 64'd1);
        check("post hs out_valid", 64'(ia.out_valid), 64'd0);
        tick();
        ia.in_valid = 1'b0;
        check("second accept busy", 64'(ia.busy), 64'd1);
        a_wait_out(lat);
        check("second latency", 64'(lat), 64'd4);
        check("second pixel", 64'(ia.pixel_out), 64'h0300);
        a_handshake();

        // Write during MAC is dropped and leaves memory intact
        a_start(16'h0400, 1'b0);
        ia.weight_we   = 1'b1;
        ia.weight_addr = 20'd0;
        ia.weight_in   = 16'h7FFF;
        tick();
        ia.weight_we = 1'b0;
        check("busy write dropped", 64'(ia.wr_dropped), 64'd1);
        tick();
        check("drop pulse one cycle", 64'(ia.wr_dropped), 64'd0);
        a_wait_out(lat);
        check("busy write job", 64'(ia.pixel_out), 64'h0400);
        a_handshake();

        // Out-of-range write while idle
        a_write(2, 16'h7FFF);
        check("range write dropped", 64'(ia.wr_dropped), 64'd1);
        tick();
        check("range pulse one cycle", 64'(ia.wr_dropped), 64'd0);
        a_start(16'h0400, 1'b0);
        a_wait_out(lat);
        check("memory unchanged", 64'(ia.pixel_out), 64'h0400);
        a_handshake();

        // Reset pulse mid-MAC aborts the job
        a_start(16'h0500, 1'b0);
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        check("abort out_valid", 64'(ia.out_valid), 64'd0);
        check("abort pixel", 64'(ia.pixel_out), 64'd0);
        check("abort in_ready", 64'(ia.in_ready), 64'd1);
        repeat (6) tick();
        check("abort no output", 64'(ia.out_valid), 64'd0);
        a_start(16'h0600, 1'b0);
        a_wait_out(lat);
        check("after abort latency", 64'(lat), 64'd4);
        check("after abort pixel", 64'(ia.pixel_out), 64'h0600);
        a_handshake();

        // Default geometry: uniform weights and samples
        for (int a = 0; a < DEPTH_B; a++) begin
            wm[a] = (a < BIAS_B) ? 256 : 0;
            b_write(a, 16'(wm[a]));
        end
        for (int t = 0; t < N_B; t++) xs[t] = 1;
        b_job(1'b0, lat);
        check("full latency", 64'(lat), 64'd1332);
        for (int oc = 0; oc < OC_B; oc++) begin
            check("full uniform lane", 64'(ib.pixel_out[oc*16 +: 16]), 64'h006C);
        end
        ib.out_ready = 1'b1;
        tick();
        ib.out_ready = 1'b0;

        // Random weights and windows against the reference model
        for (int a = 0; a < DEPTH_B; a++) begin
            if (a < BIAS_B) begin
                wm[a] = int'($urandom_range(600)) - 300;
            end else begin
                rnd = 16'($urandom);
                wm[a] = int'(rnd);
            end
            b_write(a, 16'(wm[a]));
        end
        for (int j = 0; j < 3; j++) begin
            for (int t = 0; t < N_B; t++) begin
                if (j == 0) begin
                    rnd = 16'($urandom);
                    xs[t] = int'(rnd);
                end else begin
                    xs[t] = int'($urandom_range(800)) - 400;
                end
            end
            b_job(j == 2, lat);
            check("rand latency", 64'(lat), 64'd1332);
            for (int oc = 0; oc < OC_B; oc++) begin
                check("rand lane", 64'(ib.pixel_out[oc*16 +: 16]), 64'(ref_lane(oc, j == 2)));
            end
            ib.out_ready = 1'b1;
            tick();
            ib.out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
